// File: rtl/fifo_ctrl_if.sv
// Request/grant and status bundle between the FIFO controller, its producer/consumer
// and the storage array.
interface fifo_ctrl_if #(
  parameter int PTR_L = 3
);
  // Handshake: push_req/pop_req are requests. push/pop are the grants, valid in the same cycle.
  // A transfer happens at the rising edge where the grant is high. A request with no grant transfers nothing.
  logic             push_req;
  logic             pop_req;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic [PTR_L:0]   count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow_err;
  logic             underflow_err;
  logic             valid_out;

  modport master (
    output push_req, pop_req,
    input  push, pop, wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err, valid_out
  );

  modport slave (
    input  push_req, pop_req,
    output push, pop, wr_ptr, rd_ptr, count, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err, valid_out
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO control half: pointers, occupancy, status flags, sticky error bits and read-valid strobe
// for an external registered-read storage array.
module fifo_ctrl #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 3,
  parameter int AF_THR   = 3,
  parameter int AE_THR   = 1
) (
  input  logic        clk,
  input  logic        reset_L,
  fifo_ctrl_if.slave  bus
);
  localparam logic [PTR_L:0]   SIZE_C = (PTR_L+1)'(MEM_SIZE);
  localparam logic [PTR_L:0]   AF_C   = (PTR_L+1)'(AF_THR);
  localparam logic [PTR_L:0]   AE_C   = (PTR_L+1)'(AE_THR);
  localparam logic [PTR_L-1:0] LAST_C = PTR_L'(MEM_SIZE - 1);

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             valid_q, valid_d;
  logic             full, empty, push_g, pop_g;

  always_comb begin
    full  = (count_q == SIZE_C);
    empty = (count_q == '0);
    // When full, a simultaneous pop frees the slot the push overwrites in the same edge.
    push_g = reset_L & bus.push_req & (~full | bus.pop_req);
    pop_g  = reset_L & bus.pop_req & ~empty;

    wr_ptr_d = wr_ptr_q;
    if (push_g) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop_g)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

    count_d = count_q;
    if (push_g & ~pop_g)      count_d = count_q + 1'b1;
    else if (pop_g & ~push_g) count_d = count_q - 1'b1;

    ovf_d   = ovf_q | (bus.push_req & full & ~bus.pop_req);
    unf_d   = unf_q | (bus.pop_req & empty);
    valid_d = pop_g;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.push          = push_g;
  assign bus.pop           = pop_g;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.count         = count_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.almost_full   = (count_q >= AF_C);
  assign bus.almost_empty  = (count_q <= AE_C);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.valid_out     = valid_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random traffic against an occupancy model,
// with a behavioural storage array whose read data is scoreboarded in push order.
module tb_fifo_ctrl;
  localparam int MEM_SIZE = 4;
  localparam int PTR_L    = 3;
  localparam int AF_THR   = 3;
  localparam int AE_THR   = 1;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.PTR_L(PTR_L)) bus ();

  fifo_ctrl #(
    .MEM_SIZE(MEM_SIZE), .PTR_L(PTR_L), .AF_THR(AF_THR), .AE_THR(AE_THR)
  ) u_dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Storage array with registered read; a same-edge write does not affect the read.
  logic [7:0] mem [0:(1<<PTR_L)-1];
  logic [7:0] data_out_MM;
  logic [7:0] wdata;
  always @(posedge clk) begin
    if (bus.pop)  data_out_MM <= mem[bus.rd_ptr];
    if (bus.push) mem[bus.wr_ptr] <= wdata;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  // Reference model: occupancy, transfer totals and error history.
  int   m_cnt, m_wr, m_rd;
  logic m_ovf, m_unf, m_vld;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wr = 0; m_rd = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".wr_ptr"}, bus.wr_ptr, m_wr);
    chk({tag, ".rd_ptr"}, bus.rd_ptr, m_rd);
    chk({tag, ".count"}, bus.count, m_cnt);
    chk({tag, ".full"}, bus.full, m_cnt == MEM_SIZE);
    chk({tag, ".empty"}, bus.empty, m_cnt == 0);
    chk({tag, ".almost_full"}, bus.almost_full, m_cnt >= AF_THR);
    chk({tag, ".almost_empty"}, bus.almost_empty, m_cnt <= AE_THR);
    chk({tag, ".overflow_err"}, bus.overflow_err, m_ovf);
    chk({tag, ".underflow_err"}, bus.underflow_err, m_unf);
    chk({tag, ".valid_out"}, bus.valid_out, m_vld);
  endtask

  // One clock of requests: inputs change just after a rising edge, outputs checked at the falling edge.
  task automatic step(input logic pu, input logic po);
    logic ep, eq;
    bus.push_req = pu;
    bus.pop_req  = po;
    wdata = 8'($urandom);
    @(negedge clk);
    ep = pu && ((m_cnt < MEM_SIZE) || po);
    eq = po && (m_cnt > 0);
    chk("push", bus.push, ep);
    chk("pop", bus.pop, eq);
    chk_status("step");
    if (ep) exp_q.push_back(wdata);
    @(posedge clk);
    if (pu && m_cnt == MEM_SIZE && !po) m_ovf = 1'b1;
    if (po && m_cnt == 0) m_unf = 1'b1;
    if (ep) begin m_wr = (m_wr + 1) % MEM_SIZE; m_cnt++; end
    if (eq) begin m_rd = (m_rd + 1) % MEM_SIZE; m_cnt--; end
    m_vld = eq;
    #1;
  endtask

  // Asynchronous reset dropped between edges while requests are active.
  task automatic mid_reset();
    bus.push_req = 1'b1;
    bus.pop_req  = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    chk("rst.push", bus.push, 0);
    chk("rst.pop", bus.pop, 0);
    chk_status("rst");
    @(posedge clk);
    #3;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid_out cycle must present the oldest outstanding pushed word.
  always @(negedge clk) begin
    if (reset_L && bus.valid_out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL data_out: valid_out with no outstanding word, got %0h at %0t", data_out_MM, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out_MM !== e) begin
          miscompares++;
          $display("FAIL data_out: got %0h expected %0h at %0t", data_out_MM, e, $time);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    wdata = '0;
    model_reset();
    #1;
    chk("init.push", bus.push, 0);
    chk_status("init");
    repeat (2) @(posedge clk);
    #3 reset_L = 1'b1;
    @(posedge clk);
    #1;

    step(0, 0);                                    // idle after reset
    for (int i = 0; i < 4; i++) step(1, 0);        // fill
    step(1, 0);                                    // refused push while full
    for (int i = 0; i < 4; i++) step(0, 1);        // drain in order
    step(0, 0);
    step(1, 1);                                    // empty: push only, underflow
    step(0, 0);
    step(0, 1);
    for (int i = 0; i < 4; i++) step(1, 0);
    for (int i = 0; i < 3; i++) step(1, 1);        // full: both granted
    mid_reset();

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 45));
    end
    step(0, 0);
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control half of the FIFO: owns the write and read pointers, fill count and status flags, and drives the `push`/`pop`/`wr_ptr`/`rd_ptr` inputs of the `memory` storage array. Producer and consumer requests are filtered against full/empty, and overflow/underflow attempts are recorded. A `valid_out` strobe is generated aligned with the memory's registered `data_out_MM`.

## Interface
- MEM_SIZE, 4, number of FIFO entries (any value 2..2^PTR_L, not required to be a power of two)
- PTR_L, 3, pointer width; must match the memory instance
- AF_THR, 3, almost_full asserted when count >= AF_THR
- AE_THR, 1, almost_empty asserted when count <= AE_THR
- clk  in  1  single clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- push_req  in  1  producer write request (data presented to memory in the same cycle)
- pop_req  in  1  consumer read request
- push  out  1  write strobe to memory (granted push_req)
- pop  out  1  read strobe to memory (granted pop_req)
- wr_ptr  out  PTR_L  write address to memory
- rd_ptr  out  PTR_L  read address to memory
- count  out  PTR_L+1  current occupancy, 0..MEM_SIZE
- full  out  1  count == MEM_SIZE
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THR
- almost_empty  out  1  count <= AE_THR
- overflow_err  out  1  sticky: push_req refused while full
- underflow_err  out  1  sticky: pop_req refused while empty
- valid_out  out  1  data_out_MM holds a popped word this cycle

## Operation
- State: wr_ptr, rd_ptr, count, overflow_err, underflow_err, valid_out registers; all other outputs decode combinationally from these plus the requests.
- Grant rules:
  - pop = pop_req & !empty.
  - push = push_req & (!full | pop_req).
- Full with both requests: both are granted. The memory reads the oldest word and overwrites the same slot at the same edge; the read returns the old value.
- Empty with both requests: only the push is granted, pop = 0, and underflow_err sets.
- Pointer update on a rising edge: a pointer advances by 1 when its strobe is granted. The value MEM_SIZE-1 wraps to 0.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. Count never leaves 0..MEM_SIZE.
- Errors:
  - overflow_err sets on push_req & full & !pop_req.
  - underflow_err sets on pop_req & empty.
  - Both are sticky until reset_L is low. A refused request changes no pointer and no count.
- valid_out <= pop (registered). It is high exactly in the cycle the memory presents the popped word.
- Flags full, empty, almost_full and almost_empty decode from the count register only. There is no combinational path from the requests to the flags.

## Timing
- Reset (reset_L low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, overflow_err = 0, underflow_err = 0, valid_out = 0. This gives empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- While reset_L is low, push = pop = 0 regardless of requests. Release is synchronous to the next rising edge.
- push, pop and the pointers are valid combinationally within the request cycle. The memory samples them at the closing edge.
- Write latency: a word pushed at edge k is poppable in cycle k+1 (empty deasserts after edge k).
- Read latency: 1 cycle. A pop granted at edge k gives data_out_MM and valid_out = 1 in cycle k+1.
- Reset asserted mid-operation: all stored state clears immediately and the FIFO contents are treated as discarded. valid_out drops without waiting for a clock edge.

## Test plan
Parameters for all scenarios: MEM_SIZE = 4, AF_THR = 3, AE_THR = 1.

1. Reset, no requests -> wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, errors = 0, push = pop = 0.
2. Four consecutive push_req cycles -> wr_ptr steps 0, 1, 2, 3, 0; count steps 1..4; almost_empty drops at count 2; almost_full rises at count 3; full rises at count 4.
3. Full, push_req only -> push = 0, wr_ptr stays 0, count stays 4, overflow_err = 1 and stays 1 through the following normal traffic.
4. Full, four pop_req cycles -> rd_ptr steps 0..3 then 0. valid_out is high in each following cycle, and data_out_MM returns the words in push order. After the last pop, empty = 1.
5. Empty, pop_req together with push_req -> pop = 0, push = 1, count = 1, underflow_err = 1, valid_out stays 0 next cycle.
6. Full, push_req and pop_req together for 3 cycles -> both strobes granted each cycle, count holds 4, both pointers advance 3 steps with wrap, no error. Then pull reset_L low mid-cycle -> all outputs return to reset values before the next edge.
